oled_spi_arb: RTL and testbench

- Shares the single OLED SPI byte engine between three word producers, one port per requester:
  - requester 0: power-up init sequencer
  - requester 1: frame/page refresh writer
  - requester 2: ad-hoc command port (contrast, scroll, on/off)
- Fixed priority for requester 0; round-robin between requesters 1 and 2.
- Burst locking keeps multi-word command sequences atomic.
- Drives the SPI's start/done handshake and 10-bit word bus. An optional watchdog detects a hung SPI.

---
 rtl/oled_spi_arb.sv | 230 +++++++++++++++++++++++
 tb/tb_oled_spi_arb.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/oled_spi_arb.sv
// Arbiter sharing one OLED SPI word engine between init, refresh and command ports.
// Optional hung-SPI watchdog is compiled in with `define OLED_ARB_WATCHDOG_EN.
module oled_spi_arb #(
    parameter int DW     = 10,
    parameter int TO_CYC = 50000,
    parameter int TO_W   = 16
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic [2:0]      req_i,
    input  logic [3*DW-1:0] data_i,
    input  logic [2:0]      last_i,
    output logic [2:0]      gnt_o,
    output logic [2:0]      ack_o,
    output logic            spi_start_o,
    output logic [DW-1:0]   spi_data_o,
    input  logic            spi_done_i,
    output logic            busy_o,
    output logic            err_o,
    input  logic            err_clr_i
);

    // state   | meaning
    // S_IDLE  | no owner; pick one when any request is up
    // S_GRANT | grant registered, owner gets one cycle to settle
    // S_LOAD  | capture owner word and pulse start (or release if request dropped)
    // S_WAIT  | waiting for the SPI completion pulse
    // S_DONE  | ack the word; continue the burst or release
    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_LOAD,
        S_WAIT,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    owner_q, owner_d;
    logic [2:0]    gnt_q, gnt_d;
    logic          last_q, last_d;
    logic          rr_q, rr_d;
    logic [DW-1:0] spi_data_q, spi_data_d;

    logic          own_req;
    logic          own_last;
    logic [DW-1:0] own_data;
    logic [1:0]    sel;
    logic          rr_end;
    logic          spi_start;

`ifdef OLED_ARB_WATCHDOG_EN
    logic [TO_W-1:0] wd_q, wd_d;
    logic            wd_expire;
    logic            err_q, err_d;
    logic            err_set;
`endif

    always_comb begin
        own_req  = 1'b0;
        own_last = 1'b0;
        own_data = '0;
        case (owner_q)
            2'd0: begin
                own_req  = req_i[0];
                own_last = last_i[0];
                own_data = data_i[0 +: DW];
            end
            2'd1: begin
                own_req  = req_i[1];
                own_last = last_i[1];
                own_data = data_i[DW +: DW];
            end
            2'd2: begin
                own_req  = req_i[2];
                own_last = last_i[2];
                own_data = data_i[2*DW +: DW];
            end
            default: ;
        endcase
    end

    // rr_q = 0 prefers requester 1, rr_q = 1 prefers requester 2
    always_comb begin
        sel = 2'd2;
        if (req_i[0]) begin
            sel = 2'd0;
        end else if (req_i[1] && (!req_i[2] || !rr_q)) begin
            sel = 2'd1;
        end
    end

    always_comb begin
        rr_end = rr_q;
        if (owner_q == 2'd1) begin
            rr_end = 1'b1;
        end else if (owner_q == 2'd2) begin
            rr_end = 1'b0;
        end
    end

`ifdef OLED_ARB_WATCHDOG_EN
    assign wd_expire = (wd_q == TO_W'(TO_CYC - 1));
`endif

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        gnt_d      = gnt_q;
        last_d     = last_q;
        rr_d       = rr_q;
        spi_data_d = spi_data_q;
        spi_start  = 1'b0;
`ifdef OLED_ARB_WATCHDOG_EN
        err_set    = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (req_i != 3'b000) begin
                    owner_d = sel;
                    gnt_d   = 3'b001 << sel;
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                state_d = S_LOAD;
            end
            S_LOAD: begin
                if (own_req) begin
                    spi_start  = 1'b1;
                    spi_data_d = own_data;
                    last_d     = own_last;
                    state_d    = S_WAIT;
                end else begin
                    gnt_d   = 3'b000;
                    owner_d = 2'd3;
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (spi_done_i) begin
                    state_d = S_DONE;
                end
`ifdef OLED_ARB_WATCHDOG_EN
                else if (wd_expire) begin
                    err_set = 1'b1;
                    gnt_d   = 3'b000;
                    owner_d = 2'd3;
                    rr_d    = rr_end;
                    state_d = S_IDLE;
                end
`endif
            end
            S_DONE: begin
                if (last_q) begin
                    gnt_d   = 3'b000;
                    owner_d = 2'd3;
                    rr_d    = rr_end;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_LOAD;
                end
            end
            default: begin
                gnt_d   = 3'b000;
                owner_d = 2'd3;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= S_IDLE;
            owner_q    <= 2'd3;
            gnt_q      <= 3'b000;
            last_q     <= 1'b0;
            rr_q       <= 1'b0;
            spi_data_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            gnt_q      <= gnt_d;
            last_q     <= last_d;
            rr_q       <= rr_d;
            spi_data_q <= spi_data_d;
        end
    end

`ifdef OLED_ARB_WATCHDOG_EN
    always_comb begin
        wd_d = wd_q;
        if (state_q == S_LOAD) begin
            wd_d = '0;
        end else if (state_q == S_WAIT) begin
            wd_d = wd_q + 1'b1;
        end
        err_d = err_q;
        if (err_set) begin
            err_d = 1'b1;
        end else if (err_clr_i) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`else
    localparam int unused_wd_cfg = TO_CYC + TO_W;
    logic unused_err_clr;
    assign unused_err_clr = err_clr_i;
    assign err_o          = 1'b0;
`endif

    // Word is captured in LOAD but forwarded the same cycle so START and DATA coincide
    assign spi_data_o  = spi_start ? own_data : spi_data_q;
    assign spi_start_o = spi_start;
    assign gnt_o       = gnt_q;
    assign ack_o       = (state_q == S_DONE) ? gnt_q : 3'b000;
    assign busy_o      = (state_q != S_IDLE);

endmodule

// File: tb/tb_oled_spi_arb.sv
// Directed bench for oled_spi_arb: per-cycle vector table plus hand sequences
// for burst lock, priority, abort, async reset and (when compiled in) the watchdog.
module tb_oled_spi_arb;

    localparam int DW = 10;
    localparam logic [3*DW-1:0] DATA_A = {10'h2C5, 10'h0AE, 10'h0E3};

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [2:0]    req = 3'b000;
    logic [3*DW-1:0] data = '0;
    logic [2:0]    last = 3'b000;
    logic          done = 1'b0;
    logic          clr = 1'b0;
    logic [2:0]    gnt, ack;
    logic          start, busy, err;
    logic [DW-1:0] sdata;

    logic [3*DW-1:0] dat_nx = DATA_A;
    logic            clr_nx = 1'b0;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [2:0] req;
        logic [2:0] last;
        logic       done;
        logic [2:0] gnt;
        logic [2:0] ack;
        logic       st;
        logic       busy;
        logic [9:0] sd;
    } vec_t;

    vec_t vecs[$];

    oled_spi_arb #(.DW(DW), .TO_CYC(20), .TO_W(16)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .req_i       (req),
        .data_i      (data),
        .last_i      (last),
        .gnt_o       (gnt),
        .ack_o       (ack),
        .spi_start_o (start),
        .spi_data_o  (sdata),
        .spi_done_i  (done),
        .busy_o      (busy),
        .err_o       (err),
        .err_clr_i   (clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs on the falling edge and settle before checks
    task automatic drive(input logic [2:0] r, input logic [2:0] l, input logic d);
        @(negedge clk);
        req  = r;
        last = l;
        done = d;
        data = dat_nx;
        clr  = clr_nx;
        #1;
    endtask

    task automatic add(input int n, input logic [2:0] r, input logic [2:0] l, input logic d,
                       input logic [2:0] g, input logic [2:0] a, input logic s,
                       input logic b, input logic [9:0] sd);
        vec_t v;
        v.req = r; v.last = l; v.done = d; v.gnt = g; v.ack = a;
        v.st = s; v.busy = b; v.sd = sd;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    task automatic add_burst(input logic [2:0] g, input logic [9:0] sprev,
                             input logic [9:0] s, input logic stray);
        add(1, 3'b110, 3'b111, 1'b0,  3'b000, 3'b000, 1'b0, 1'b0, sprev);
        add(1, 3'b110, 3'b111, stray, g,      3'b000, 1'b0, 1'b1, sprev);
        add(1, 3'b110, 3'b111, 1'b0,  g,      3'b000, 1'b1, 1'b1, s);
        add(1, 3'b110, 3'b111, 1'b1,  g,      3'b000, 1'b0, 1'b1, s);
        add(1, 3'b110, 3'b111, 1'b0,  g,      g,      1'b0, 1'b1, s);
    endtask

    task automatic burst_quick(input string nm, input logic [2:0] r, input int idx);
        logic [2:0] g;
        logic [9:0] s;
        g = 3'b001 << idx;
        s = 10'(DATA_A >> (idx * DW));
        drive(r, 3'b111, 1'b0); chk({nm, " idle gnt"}, gnt, 3'b000);
        drive(r, 3'b111, 1'b0); chk({nm, " gnt"}, gnt, g);
        drive(r, 3'b111, 1'b0); chk({nm, " start"}, start, 1'b1);
                                chk({nm, " sdata"}, sdata, s);
        drive(r, 3'b111, 1'b1);
        drive(r, 3'b111, 1'b0); chk({nm, " ack"}, ack, g);
    endtask

    initial begin
        // single word from requester 1, then round-robin (pointer now prefers 2)
        add(1, 3'b000, 3'b111, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 10'h000);
        add(1, 3'b010, 3'b111, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 10'h000);
        add(1, 3'b010, 3'b111, 1'b0, 3'b010, 3'b000, 1'b0, 1'b1, 10'h000);
        add(1, 3'b010, 3'b111, 1'b0, 3'b010, 3'b000, 1'b1, 1'b1, 10'h0AE);
        add(7, 3'b010, 3'b111, 1'b0, 3'b010, 3'b000, 1'b0, 1'b1, 10'h0AE);
        add(1, 3'b010, 3'b111, 1'b1, 3'b010, 3'b000, 1'b0, 1'b1, 10'h0AE);
        add(1, 3'b010, 3'b111, 1'b0, 3'b010, 3'b010, 1'b0, 1'b1, 10'h0AE);
        add(1, 3'b000, 3'b111, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 10'h0AE);
        add_burst(3'b100, 10'h0AE, 10'h2C5, 1'b1);
        add_burst(3'b010, 10'h2C5, 10'h0AE, 1'b0);
        add_burst(3'b100, 10'h0AE, 10'h2C5, 1'b0);
        add_burst(3'b010, 10'h2C5, 10'h0AE, 1'b0);
        add(1, 3'b000, 3'b111, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 10'h0AE);

        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].req, vecs[i].last, vecs[i].done);
            chk($sformatf("vec%0d gnt", i),   gnt,   vecs[i].gnt);
            chk($sformatf("vec%0d ack", i),   ack,   vecs[i].ack);
            chk($sformatf("vec%0d start", i), start, vecs[i].st);
            chk($sformatf("vec%0d busy", i),  busy,  vecs[i].busy);
            chk($sformatf("vec%0d sdata", i), sdata, vecs[i].sd);
            chk($sformatf("vec%0d err", i),   err,   1'b0);
        end

        // burst lock: requester 2 three words, requester 0 arrives during word 1
        dat_nx = {10'h3A1, DATA_A[2*DW-1:0]};
        drive(3'b100, 3'b000, 1'b0); chk("lock idle gnt", gnt, 3'b000);
        drive(3'b100, 3'b000, 1'b0); chk("lock gnt", gnt, 3'b100);
        drive(3'b101, 3'b000, 1'b0); chk("lock w1 start", start, 1'b1);
                                     chk("lock w1 data", sdata, 10'h3A1);
        drive(3'b101, 3'b000, 1'b1); chk("lock w1 wait gnt", gnt, 3'b100);
        drive(3'b101, 3'b000, 1'b0); chk("lock w1 ack", ack, 3'b100);
        dat_nx = {10'h155, DATA_A[2*DW-1:0]};
        drive(3'b101, 3'b000, 1'b0); chk("lock w2 start", start, 1'b1);
                                     chk("lock w2 data", sdata, 10'h155);
                                     chk("lock w2 gnt", gnt, 3'b100);
        drive(3'b101, 3'b000, 1'b1);
        drive(3'b101, 3'b000, 1'b0); chk("lock w2 ack", ack, 3'b100);
        dat_nx = {10'h2FF, DATA_A[2*DW-1:0]};
        drive(3'b101, 3'b100, 1'b0); chk("lock w3 data", sdata, 10'h2FF);
                                     chk("lock w3 gnt", gnt, 3'b100);
        drive(3'b101, 3'b100, 1'b1);
        drive(3'b101, 3'b100, 1'b0); chk("lock w3 ack", ack, 3'b100);
                                     chk("lock w3 ack gnt", gnt, 3'b100);
        dat_nx = DATA_A;
        drive(3'b001, 3'b001, 1'b0); chk("lock release gnt", gnt, 3'b000);
                                     chk("lock release busy", busy, 1'b0);
        drive(3'b001, 3'b001, 1'b0); chk("lock r0 gnt", gnt, 3'b001);
        drive(3'b001, 3'b001, 1'b0); chk("lock r0 data", sdata, 10'h0E3);
        drive(3'b001, 3'b001, 1'b1);
        drive(3'b000, 3'b001, 1'b0); chk("lock r0 ack", ack, 3'b001);

        // priority: requester 0 wins while up, then 1 and 2 alternate
        burst_quick("prio a", 3'b111, 0);
        burst_quick("prio b", 3'b111, 0);
        burst_quick("prio c", 3'b110, 1);
        burst_quick("prio d", 3'b110, 2);
        drive(3'b000, 3'b000, 1'b0); chk("prio end busy", busy, 1'b0);

        // abort: burst continues but the request is gone by the next LOAD
        drive(3'b010, 3'b000, 1'b0);
        drive(3'b010, 3'b000, 1'b0); chk("abort gnt", gnt, 3'b010);
        drive(3'b010, 3'b000, 1'b0); chk("abort w1 start", start, 1'b1);
        drive(3'b010, 3'b000, 1'b1);
        drive(3'b010, 3'b000, 1'b0); chk("abort w1 ack", ack, 3'b010);
        dat_nx = {DATA_A[3*DW-1:2*DW], 10'h111, DATA_A[DW-1:0]};
        drive(3'b000, 3'b000, 1'b0); chk("abort load start", start, 1'b0);
                                     chk("abort load data hold", sdata, 10'h0AE);
        drive(3'b000, 3'b000, 1'b0); chk("abort gnt drop", gnt, 3'b000);
                                     chk("abort busy", busy, 1'b0);
                                     chk("abort err", err, 1'b0);
        drive(3'b000, 3'b000, 1'b0); chk("abort no start", start, 1'b0);
        dat_nx = DATA_A;

        // asynchronous reset in the middle of a WAIT
        drive(3'b100, 3'b100, 1'b0);
        drive(3'b100, 3'b100, 1'b0);
        drive(3'b100, 3'b100, 1'b0);
        drive(3'b100, 3'b100, 1'b0); chk("rst pre busy", busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst gnt", gnt, 3'b000);
        chk("rst busy", busy, 1'b0);
        chk("rst start", start, 1'b0);
        chk("rst sdata", sdata, 10'h000);
        drive(3'b000, 3'b000, 1'b0);
        rst_n = 1'b1;
        drive(3'b000, 3'b000, 1'b0); chk("rst after busy", busy, 1'b0);

        // hung SPI: 20 WAIT cycles without done
        drive(3'b010, 3'b010, 1'b0);
        drive(3'b010, 3'b010, 1'b0);
        drive(3'b010, 3'b010, 1'b0); chk("wd start", start, 1'b1);
        for (int k = 1; k <= 20; k++) begin
            drive(3'b010, 3'b010, 1'b0);
            chk($sformatf("wd wait%0d busy", k), busy, 1'b1);
            chk($sformatf("wd wait%0d err", k), err, 1'b0);
        end
`ifdef OLED_ARB_WATCHDOG_EN
        drive(3'b000, 3'b010, 1'b0); chk("wd err set", err, 1'b1);
                                     chk("wd busy", busy, 1'b0);
                                     chk("wd gnt", gnt, 3'b000);
                                     chk("wd no ack", ack, 3'b000);
        clr_nx = 1'b1;
        drive(3'b000, 3'b010, 1'b0); chk("wd err sticky", err, 1'b1);
        clr_nx = 1'b0;
        drive(3'b000, 3'b010, 1'b0); chk("wd err clr", err, 1'b0);
        // done arriving on the expiry cycle wins over the timeout
        drive(3'b010, 3'b010, 1'b0);
        drive(3'b010, 3'b010, 1'b0);
        drive(3'b010, 3'b010, 1'b0);
        for (int k = 1; k <= 20; k++) drive(3'b010, 3'b010, (k == 20));
        drive(3'b000, 3'b010, 1'b0); chk("wd edge ack", ack, 3'b010);
                                     chk("wd edge err", err, 1'b0);
        drive(3'b000, 3'b000, 1'b0); chk("wd edge idle", busy, 1'b0);
`else
        drive(3'b010, 3'b010, 1'b0); chk("nowd still busy", busy, 1'b1);
                                     chk("nowd err", err, 1'b0);
        clr_nx = 1'b1;
        drive(3'b010, 3'b010, 1'b1); chk("nowd clr err", err, 1'b0);
        clr_nx = 1'b0;
        drive(3'b000, 3'b010, 1'b0); chk("nowd ack", ack, 3'b010);
        drive(3'b000, 3'b000, 1'b0); chk("nowd idle", busy, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
